// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample buffer: stereo sample pair,
// buffer FSM states and the txBegin synchroniser depth.
package i2s_pkg;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_t;

  typedef enum logic [1:0] {IDLE, PRIME, LOAD, RUN} buf_state_t;

  localparam stereo_t SILENCE = '0;

  // meta, sync, and previous-value stages for the txBegin edge detector
  localparam int SYNC_STAGES = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock RAM FIFO with flush, exact level counter and first-word-through
// read data (rdata_o always shows the head entry while not empty).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full/empty are taken from the registered level, so a push while full is
  // refused even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_sample_buffer.sv
// Stereo sample buffer feeding the I2S transmitter: primes a FIFO, then serves
// one held L/R pair per synchronised txBegin edge, substituting silence on underrun.
module i2s_sample_buffer
  import i2s_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                   CLK50MHZ,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic [15:0]            inSampleL,
  input  logic [15:0]            inSampleR,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   txBegin,
  output logic [15:0]            sampleL,
  output logic [15:0]            sampleR,
  output logic                   txEnable,
  output logic [$clog2(DEPTH):0] fifoLevel,
  output logic                   underrun,
  output logic [15:0]            underrunCnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  buf_state_t             state_q;
  stereo_t                sample_q;
  logic                   tx_en_q, underrun_q;
  logic [15:0]            urun_cnt_q;
  logic [SYNC_STAGES-1:0] tx_pipe_q;
  logic                   pop_req_q;

  stereo_t       push_data, head_data;
  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  assign push_data  = '{l: inSampleL, r: inSampleR};
  assign inReady    = enable & (state_q != IDLE) & ~fifo_full;
  assign fifo_push  = inValid & inReady;
  assign fifo_pop   = enable & ((state_q == LOAD) | ((state_q == RUN) & pop_req_q));
  assign fifo_flush = ~enable | (state_q == IDLE);

  sync_fifo #(
    .WIDTH ($bits(stereo_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK50MHZ),
    .rst_ni  (resetN),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (push_data),
    .pop_i   (fifo_pop),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // txBegin crosses from the BitClk domain; registering the edge pulse puts
  // popReq three cycles after the txBegin rise, and outputs move one later.
  always_ff @(posedge CLK50MHZ or negedge resetN) begin
    if (!resetN) begin
      tx_pipe_q <= '0;
      pop_req_q <= 1'b0;
    end else begin
      tx_pipe_q <= {tx_pipe_q[SYNC_STAGES-2:0], txBegin};
      pop_req_q <= tx_pipe_q[1] & ~tx_pipe_q[2];
    end
  end

  always_ff @(posedge CLK50MHZ or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      sample_q   <= SILENCE;
      tx_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        sample_q <= SILENCE;
        tx_en_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE:  state_q <= PRIME;
          PRIME: if (fifo_level >= PRIME_LVL) state_q <= LOAD;
          LOAD: begin
            sample_q <= head_data;
            tx_en_q  <= 1'b1;
            state_q  <= RUN;
          end
          RUN: begin
            // Underrun keeps framing with silence rather than re-priming.
            if (pop_req_q) begin
              if (!fifo_empty) begin
                sample_q <= head_data;
              end else begin
                sample_q   <= SILENCE;
                underrun_q <= 1'b1;
                urun_cnt_q <= sat_inc16(urun_cnt_q);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sampleL     = sample_q.l;
  assign sampleR     = sample_q.r;
  assign txEnable    = tx_en_q;
  assign fifoLevel   = fifo_level;
  assign underrun    = underrun_q;
  assign underrunCnt = urun_cnt_q;

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Bench for i2s_sample_buffer: table-driven priming, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_i2s_sample_buffer;
  import i2s_pkg::*;

  localparam int DEPTH = 8;
  localparam int PL    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          tx_begin = 1'b0;
  logic [15:0]   in_l = '0, in_r = '0;
  logic          in_ready, tx_en, und;
  logic [15:0]   s_l, s_r, und_cnt;
  logic [LW-1:0] level;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  i2s_sample_buffer #(.DEPTH(DEPTH), .PRIME_LEVEL(PL)) dut (
    .CLK50MHZ    (clk),
    .resetN      (rst_n),
    .enable      (en),
    .inSampleL   (in_l),
    .inSampleR   (in_r),
    .inValid     (in_valid),
    .inReady     (in_ready),
    .txBegin     (tx_begin),
    .sampleL     (s_l),
    .sampleR     (s_r),
    .txEnable    (tx_en),
    .fifoLevel   (level),
    .underrun    (und),
    .underrunCnt (und_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_l = l; in_r = r; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic tx_pulse(input int hi, output int n_und);
    n_und = 0;
    tx_begin = 1'b1;
    for (int i = 0; i < hi; i++) begin step(); if (und) n_und++; end
    tx_begin = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (und) n_und++; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_txen"},  tx_en,    0);
    chk({tag, "_level"}, level,    0);
    chk({tag, "_sl"},    s_l,      0);
    chk({tag, "_sr"},    s_r,      0);
    chk({tag, "_und"},   und,      0);
    chk({tag, "_ucnt"},  und_cnt,  0);
    chk({tag, "_rdy"},   in_ready, 0);
  endtask

  typedef struct {
    logic          en, v;
    logic [15:0]   l, r;
    logic          exp_txen;
    logic [LW-1:0] exp_lvl;
    logic [15:0]   exp_l, exp_r;
    logic          exp_rdy;
  } vec_t;

  vec_t tbl[8];

  // reference model state
  stereo_t     mq[$];
  int          mst;            // 0 idle, 1 priming, 2 load, 3 streaming
  logic [15:0] m_l, m_r, m_cnt;
  logic        m_txen, m_und;
  logic [4:0]  txh;

  initial begin
    int n;
    stereo_t hd;
    logic exp_rdy, acc, pop_ev;
    int off_cnt, rate, tx_cnt;

    // reset state
    repeat (2) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("reset_rel");

    // priming: txEnable waits for PRIME_LEVEL entries
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, LW'(0), 16'h0, 16'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 16'h0001, 16'h8001, 1'b0, LW'(1), 16'h0, 16'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 16'h0002, 16'h8002, 1'b0, LW'(2), 16'h0, 16'h0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 16'h0003, 16'h8003, 1'b0, LW'(3), 16'h0, 16'h0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, LW'(3), 16'h0, 16'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 16'h0004, 16'h8004, 1'b0, LW'(4), 16'h0, 16'h0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, LW'(4), 16'h0, 16'h0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, LW'(3), 16'h0001, 16'h8001, 1'b1};
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; in_valid = tbl[i].v; in_l = tbl[i].l; in_r = tbl[i].r;
      step();
      chk($sformatf("prime%0d_txen", i),  tx_en,    tbl[i].exp_txen);
      chk($sformatf("prime%0d_level", i), level,    tbl[i].exp_lvl);
      chk($sformatf("prime%0d_sl", i),    s_l,      tbl[i].exp_l);
      chk($sformatf("prime%0d_sr", i),    s_r,      tbl[i].exp_r);
      chk($sformatf("prime%0d_rdy", i),   in_ready, tbl[i].exp_rdy);
    end
    in_valid = 1'b0;

    // 36-cycle txBegin: exactly one pop, landing 4 clocks after the edge
    tx_begin = 1'b1;
    repeat (3) step();
    chk("tx36_before_sl", s_l, 16'h0001);
    step();
    chk("tx36_sl", s_l, 16'h0002);
    chk("tx36_sr", s_r, 16'h8002);
    chk("tx36_level", level, 2);
    repeat (32) step();
    tx_begin = 1'b0;
    repeat (8) step();
    chk("tx36_once_sl", s_l, 16'h0002);
    chk("tx36_once_level", level, 2);

    // drain, then underrun with silence
    tx_pulse(5, n);
    tx_pulse(5, n);
    chk("drain_sl", s_l, 16'h0004);
    chk("drain_level", level, 0);
    chk("drain_und", n, 0);
    tx_pulse(5, n);
    chk("urun_sl", s_l, 0);
    chk("urun_sr", s_r, 0);
    chk("urun_pulses", n, 1);
    chk("urun_cnt", und_cnt, 1);
    chk("urun_txen", tx_en, 1);
    push(16'h00AA, 16'h1234);
    tx_pulse(5, n);
    chk("recover_sl", s_l, 16'h00AA);
    chk("recover_sr", s_r, 16'h1234);
    chk("recover_level", level, 0);

    // full FIFO: held 9th push lands the cycle after the pop
    for (int i = 0; i < DEPTH; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    chk("full_level", level, DEPTH);
    chk("full_rdy", in_ready, 0);
    in_l = 16'h0108; in_r = 16'h0208; in_valid = 1'b1; tx_begin = 1'b1;
    repeat (3) step();
    chk("full_hold_level", level, DEPTH);
    step();
    chk("full_pop_level", level, DEPTH - 1);
    chk("full_pop_sl", s_l, 16'h0100);
    chk("full_pop_rdy", in_ready, 1);
    step();
    chk("full_refill_level", level, DEPTH);
    in_valid = 1'b0;
    step();
    tx_begin = 1'b0;
    repeat (8) step();
    for (int k = 1; k <= DEPTH; k++) begin
      tx_pulse(5, n);
      chk($sformatf("order%0d_sl", k), s_l, 16'h0100 + 16'(k));
      chk($sformatf("order%0d_sr", k), s_r, 16'h0200 + 16'(k));
    end
    chk("order_level", level, 0);
    chk("order_ucnt", und_cnt, 1);

    // disable mid-stream flushes, re-enable re-primes
    push(16'h0300, 16'h0700);
    push(16'h0301, 16'h0701);
    en = 1'b0;
    step();
    chk("dis_txen", tx_en, 0);
    chk("dis_level", level, 0);
    chk("dis_sl", s_l, 0);
    chk("dis_sr", s_r, 0);
    chk("dis_rdy", in_ready, 0);
    chk("dis_ucnt", und_cnt, 1);
    en = 1'b1;
    step();
    chk("reen_txen", tx_en, 0);
    for (int i = 0; i < PL; i++) push(16'h0400 + 16'(i), 16'h0500 + 16'(i));
    step();
    chk("reen_wait_txen", tx_en, 0);
    step();
    chk("reen_txen_on", tx_en, 1);
    chk("reen_sl", s_l, 16'h0400);
    chk("reen_level", level, PL - 1);

    // asynchronous reset mid-stream
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    step();
    chk_all_zero("arst_held");
    rst_n = 1'b1;
    step();
    chk("arst_rel_txen", tx_en, 0);
    chk("arst_rel_level", level, 0);
    chk("arst_rel_sl", s_l, 0);
    chk("arst_rel_ucnt", und_cnt, 0);
    chk("arst_rel_rdy", in_ready, 1);

    // randomized traffic vs. reference model, from a fresh reset
    en = 1'b0; in_valid = 1'b0; tx_begin = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mq.delete(); mst = 0; m_l = '0; m_r = '0; m_cnt = '0; m_txen = 1'b0; m_und = 1'b0; txh = '0;
    off_cnt = 0; rate = 30; tx_cnt = 10;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 1;
          1: rate = 4;
          default: rate = 30;
        endcase
      end
      if (off_cnt == 0 && $urandom_range(0, 399) == 0) off_cnt = $urandom_range(1, 6);
      en = (off_cnt == 0);
      if (off_cnt > 0) off_cnt--;
      in_valid = ($urandom_range(0, 99) < rate);
      in_l = 16'($urandom); in_r = 16'($urandom);
      if (tx_cnt == 0) begin
        tx_begin = ~tx_begin;
        tx_cnt = tx_begin ? $urandom_range(3, 36) : $urandom_range(3, 40);
      end else tx_cnt--;
      txh = {txh[3:0], tx_begin};

      #1;
      exp_rdy = en && (mst != 0) && (mq.size() < DEPTH);
      chk("rnd_rdy", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      pop_ev = txh[3] && !txh[4];

      step();
      m_und = 1'b0;
      if (!en) begin
        mq.delete(); m_l = '0; m_r = '0; m_txen = 1'b0; mst = 0;
      end else begin
        case (mst)
          0: mst = 1;
          1: if (mq.size() >= PL) mst = 2;
          2: begin
            hd = mq.pop_front(); m_l = hd.l; m_r = hd.r; m_txen = 1'b1; mst = 3;
          end
          default: if (pop_ev) begin
            if (mq.size() > 0) begin
              hd = mq.pop_front(); m_l = hd.l; m_r = hd.r;
            end else begin
              m_l = '0; m_r = '0; m_und = 1'b1;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
          end
        endcase
        if (acc) mq.push_back('{l: in_l, r: in_r});
      end
      chk("rnd_sl", s_l, m_l);
      chk("rnd_sr", s_r, m_r);
      chk("rnd_txen", tx_en, m_txen);
      chk("rnd_level", level, mq.size());
      chk("rnd_und", und, m_und);
      chk("rnd_ucnt", und_cnt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
